stress_multi: RTL and testbench

- Parametrised successor of the single-channel stress detector: N sensor channels (heart rate, cry volume, ...) sampled on the `slow` tick.
- Each channel is windowed and averaged, and its average compared with the previous window average.
- Per-channel decreased/equal/error flags are combined into the global `gedaald`/`gelijk`/`error` consumed by the rocking controller.
- A sequential scan FSM processes one channel per clock, so one comparator and one divider are shared by all channels.

---
 rtl/stress_multi_if.sv | 29 ++
 rtl/stress_multi.sv | 183 ++++++++++++++++++
 tb/tb_stress_multi.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/stress_multi_if.sv
// Bus bundle for stress_multi: sample tick, channel data, combine controls and detector results.
// The master side drives the samples; the slave side (the detector) returns the flags.
interface stress_multi_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);
  logic                      slow;
  logic [CHANNELS*WIDTH-1:0] data;
  logic [CHANNELS-1:0]       ch_enable;
  logic                      mode;
  logic [CHANNELS-1:0]       ch_gedaald;
  logic [CHANNELS-1:0]       ch_gelijk;
  logic [CHANNELS-1:0]       ch_error;
  logic                      gedaald;
  logic                      gelijk;
  logic                      error;
  logic                      result_valid;
  logic                      overrun;

  modport master (
    output slow, data, ch_enable, mode,
    input  ch_gedaald, ch_gelijk, ch_error, gedaald, gelijk, error, result_valid, overrun
  );

  modport slave (
    input  slow, data, ch_enable, mode,
    output ch_gedaald, ch_gelijk, ch_error, gedaald, gelijk, error, result_valid, overrun
  );
endinterface

// File: rtl/stress_multi.sv
// Multi-channel stress detector: windowed averages per channel, compared with the previous window,
// scanned one channel per clock so a single comparator/divider serves every channel.
module stress_multi #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 8,
  parameter int WINDOW    = 4,
  parameter int TOL       = 2,
  parameter int MIN_VALID = 30,
  parameter int MAX_VALID = 220
) (
  input  logic          clk,
  input  logic          reset,
  stress_multi_if.slave bus
);

  localparam int LOG2W = $clog2(WINDOW);
  localparam int ACC_W = WIDTH + LOG2W;
  localparam int CNT_W = LOG2W + 1;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CMP_W = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    COMBINE = 2'd2
  } state_t;

  state_t                          state_q;
  logic [CH_W-1:0]                 ch_idx_q;
  logic [CHANNELS*WIDTH-1:0]       snap_q;
  logic [CHANNELS-1:0][ACC_W-1:0]  acc_q;
  logic [CHANNELS-1:0][CNT_W-1:0]  cnt_q;
  logic [CHANNELS-1:0][WIDTH-1:0]  prev_avg_q;
  logic [CHANNELS-1:0]             prev_valid_q;
  logic [CHANNELS-1:0]             ch_gedaald_q;
  logic [CHANNELS-1:0]             ch_gelijk_q;
  logic [CHANNELS-1:0]             ch_error_q;
  logic                            gedaald_q;
  logic                            gelijk_q;
  logic                            error_q;
  logic                            result_valid_q;
  logic                            overrun_q;

  logic [WIDTH-1:0] samp_s;
  logic             in_range_s;
  logic [ACC_W-1:0] acc_sum_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             win_done_s;
  logic [WIDTH-1:0] avg_s;
  logic             dec_s;
  logic             eq_s;
  logic             comb_gedaald_s;
  logic             comb_gelijk_s;
  logic             comb_error_s;

  function automatic logic [CMP_W-1:0] abs_diff(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b);
    logic [CMP_W-1:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

  // Shared datapath for the channel currently being scanned.
  always_comb begin
    samp_s     = snap_q[int'(ch_idx_q)*WIDTH +: WIDTH];
    in_range_s = (samp_s >= WIDTH'(MIN_VALID)) && (samp_s <= WIDTH'(MAX_VALID));
    acc_sum_s  = acc_q[ch_idx_q] + ACC_W'(samp_s);
    cnt_inc_s  = cnt_q[ch_idx_q] + CNT_W'(1);
    win_done_s = (cnt_inc_s == CNT_W'(WINDOW));
    avg_s      = acc_sum_s[ACC_W-1:LOG2W];
    dec_s      = 1'b0;
    eq_s       = 1'b0;
    // Compare one bit wider than the samples so avg + TOL cannot wrap.
    if (({1'b0, avg_s} + CMP_W'(TOL)) < {1'b0, prev_avg_q[ch_idx_q]}) begin
      dec_s = 1'b1;
    end else if (abs_diff({1'b0, avg_s}, {1'b0, prev_avg_q[ch_idx_q]}) <= CMP_W'(TOL)) begin
      eq_s = 1'b1;
    end else begin
      dec_s = 1'b0;
      eq_s  = 1'b0;
    end
  end

  // Combine enabled channels; AND mode over an empty set yields 0.
  always_comb begin
    comb_error_s = |(ch_error_q & bus.ch_enable);
    if (bus.mode) begin
      comb_gedaald_s = (&(ch_gedaald_q | ~bus.ch_enable)) & (|bus.ch_enable);
      comb_gelijk_s  = (&(ch_gelijk_q  | ~bus.ch_enable)) & (|bus.ch_enable);
    end else begin
      comb_gedaald_s = |(ch_gedaald_q & bus.ch_enable);
      comb_gelijk_s  = |(ch_gelijk_q  & bus.ch_enable);
    end
  end

  // Scan FSM together with per-channel window state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      ch_idx_q       <= '0;
      snap_q         <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      prev_avg_q     <= '0;
      prev_valid_q   <= '0;
      ch_gedaald_q   <= '0;
      ch_gelijk_q    <= '0;
      ch_error_q     <= '0;
      gedaald_q      <= 1'b0;
      gelijk_q       <= 1'b0;
      error_q        <= 1'b0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.slow) begin
            snap_q   <= bus.data;
            ch_idx_q <= '0;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          if (bus.slow) begin
            overrun_q <= 1'b1;
          end
          if (!in_range_s) begin
            // Bad sample restarts the window but keeps the reference average.
            ch_error_q[ch_idx_q] <= 1'b1;
            acc_q[ch_idx_q]      <= '0;
            cnt_q[ch_idx_q]      <= '0;
          end else if (win_done_s) begin
            acc_q[ch_idx_q]      <= '0;
            cnt_q[ch_idx_q]      <= '0;
            ch_error_q[ch_idx_q] <= 1'b0;
            prev_avg_q[ch_idx_q] <= avg_s;
            if (prev_valid_q[ch_idx_q]) begin
              ch_gedaald_q[ch_idx_q] <= dec_s;
              ch_gelijk_q[ch_idx_q]  <= eq_s;
            end else begin
              prev_valid_q[ch_idx_q] <= 1'b1;
            end
          end else begin
            acc_q[ch_idx_q] <= acc_sum_s;
            cnt_q[ch_idx_q] <= cnt_inc_s;
          end
          if (ch_idx_q == CH_W'(CHANNELS - 1)) begin
            state_q <= COMBINE;
          end else begin
            ch_idx_q <= ch_idx_q + CH_W'(1);
          end
        end
        COMBINE: begin
          if (bus.slow) begin
            overrun_q <= 1'b1;
          end
          gedaald_q      <= comb_gedaald_s;
          gelijk_q       <= comb_gelijk_s;
          error_q        <= comb_error_s;
          result_valid_q <= 1'b1;
          state_q        <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ch_gedaald   = ch_gedaald_q;
  assign bus.ch_gelijk    = ch_gelijk_q;
  assign bus.ch_error     = ch_error_q;
  assign bus.gedaald      = gedaald_q;
  assign bus.gelijk       = gelijk_q;
  assign bus.error        = error_q;
  assign bus.result_valid = result_valid_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_stress_multi.sv
// Directed bench for stress_multi (2 channels, 8-bit, window 4, TOL 2, range 30..220).
module tb_stress_multi;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   lat;
  int   rv_seen;

  stress_multi_if #(.CHANNELS(2), .WIDTH(8)) bus ();

  stress_multi #(
    .CHANNELS(2), .WIDTH(8), .WINDOW(4), .TOL(2), .MIN_VALID(30), .MAX_VALID(220)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset         = 1'b0;
    bus.slow      = 1'b0;
    bus.data      = '0;
    bus.mode      = 1'b0;
    bus.ch_enable = 2'b11;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Pulse slow with samples (d0 on ch0, d1 on ch1); dbl keeps slow high one extra cycle.
  task automatic do_tick(input logic [7:0] d0, input logic [7:0] d1, input logic dbl);
    int k;
    @(negedge clk);
    bus.data = {d1, d0};
    bus.slow = 1'b1;
    @(negedge clk);
    k = 0;
    if (dbl) begin
      @(negedge clk);
      k = 1;
    end
    bus.slow = 1'b0;
    while (!bus.result_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    lat = k;
    check_eq("latency", 32'(k), 32'd3);
  endtask

  task automatic run_ticks(input int n, input logic [7:0] d0, input logic [7:0] d1);
    for (int i = 0; i < n; i++) begin
      do_tick(d0, d1, 1'b0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // 1: reset state, reset mid-scan, first window yields no flags
    apply_reset();
    check_eq("reset_outs", 32'({bus.ch_gedaald, bus.ch_gelijk, bus.ch_error, bus.gedaald,
                                bus.gelijk, bus.error, bus.result_valid, bus.overrun}), 32'd0);
    @(negedge clk);
    bus.data = {8'd120, 8'd100};
    bus.slow = 1'b1;
    @(negedge clk);
    bus.slow = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.result_valid) rv_seen++;
    end
    check_eq("abort_no_rv", 32'(rv_seen), 32'd0);
    check_eq("abort_outs", 32'({bus.ch_gedaald, bus.ch_gelijk, bus.ch_error, bus.gedaald,
                                bus.gelijk, bus.error, bus.overrun}), 32'd0);
    run_ticks(4, 8'd100, 8'd120);
    check_eq("first_win_flags", 32'({bus.ch_gedaald, bus.ch_gelijk, bus.gedaald, bus.gelijk}), 32'd0);

    // 2: ch0 decreases, ch1 constant
    apply_reset();
    run_ticks(4, 8'd100, 8'd120);
    run_ticks(4, 8'd90, 8'd120);
    check_eq("t2_ch_gedaald", 32'(bus.ch_gedaald), 32'h1);
    check_eq("t2_ch_gelijk", 32'(bus.ch_gelijk), 32'h2);
    check_eq("t2_comb", 32'({bus.gedaald, bus.gelijk, bus.error}), 32'h6);

    // 3: equal within TOL, then rise of 3 clears both flags
    apply_reset();
    run_ticks(4, 8'd100, 8'd120);
    do_tick(8'd102, 8'd120, 1'b0);
    do_tick(8'd101, 8'd120, 1'b0);
    do_tick(8'd103, 8'd120, 1'b0);
    do_tick(8'd101, 8'd120, 1'b0);
    check_eq("t3_eq", 32'({bus.ch_gedaald[0], bus.ch_gelijk[0]}), 32'h1);
    run_ticks(4, 8'd104, 8'd120);
    check_eq("t3_rise", 32'({bus.ch_gedaald[0], bus.ch_gelijk[0]}), 32'h0);

    // 4: out-of-range sample restarts the window
    apply_reset();
    do_tick(8'd100, 8'd120, 1'b0);
    do_tick(8'd250, 8'd120, 1'b0);
    check_eq("t4_err", 32'({bus.ch_error, bus.error}), 32'h3);
    run_ticks(3, 8'd100, 8'd120);
    check_eq("t4_err_hold", 32'(bus.ch_error), 32'h1);
    do_tick(8'd100, 8'd120, 1'b0);
    check_eq("t4_err_clr", 32'({bus.ch_error, bus.error}), 32'h0);

    // 5: combine modes and enables
    apply_reset();
    run_ticks(4, 8'd100, 8'd100);
    run_ticks(4, 8'd90, 8'd110);
    check_eq("t5_or", 32'({bus.ch_gedaald, bus.gedaald}), 32'h3);
    bus.mode = 1'b1;
    do_tick(8'd90, 8'd110, 1'b0);
    check_eq("t5_and", 32'(bus.gedaald), 32'h0);
    bus.ch_enable = 2'b01;
    do_tick(8'd90, 8'd110, 1'b0);
    check_eq("t5_and_en01", 32'(bus.gedaald), 32'h1);
    bus.ch_enable = 2'b00;
    do_tick(8'd90, 8'd110, 1'b0);
    check_eq("t5_none_en", 32'({bus.gedaald, bus.gelijk, bus.error}), 32'h0);

    // 6: slow during a scan sets sticky overrun and is not sampled
    apply_reset();
    do_tick(8'd100, 8'd120, 1'b1);
    check_eq("t6_overrun", 32'(bus.overrun), 32'h1);
    run_ticks(3, 8'd100, 8'd120);
    run_ticks(3, 8'd90, 8'd120);
    check_eq("t6_not_counted", 32'(bus.ch_gedaald[0]), 32'h0);
    do_tick(8'd90, 8'd120, 1'b0);
    check_eq("t6_window", 32'(bus.ch_gedaald[0]), 32'h1);
    check_eq("t6_sticky", 32'(bus.overrun), 32'h1);

    // 7: range limits are inclusive
    apply_reset();
    do_tick(8'd30, 8'd220, 1'b0);
    check_eq("t7_in_range", 32'(bus.ch_error), 32'h0);
    do_tick(8'd29, 8'd220, 1'b0);
    check_eq("t7_below_min", 32'(bus.ch_error), 32'h1);
    do_tick(8'd30, 8'd221, 1'b0);
    check_eq("t7_above_max", 32'({bus.ch_error, bus.error}), 32'h7);

    // 8: TOL edge: drop of 3 is a decrease, drop of 2 is equal
    apply_reset();
    run_ticks(4, 8'd100, 8'd100);
    run_ticks(4, 8'd97, 8'd98);
    check_eq("t8_ch_gedaald", 32'(bus.ch_gedaald), 32'h1);
    check_eq("t8_ch_gelijk", 32'(bus.ch_gelijk), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
